demux1to4_rr: RTL and testbench
===============================

// Module: demux1to4_rr
// PURPOSE
//  1-to-4 registered stream demultiplexer with valid/ready handshake on every port.
//  Routes each accepted input word to one of four output lanes. The lane is chosen by
//  an explicit select (mode 0) or by an internal round-robin pointer (mode 1).
//  Counterpart to the 4:1 mux path: it fans one source out to four sinks, and each sink
//  can apply its own backpressure.
// PARAMETERS
//  WIDTH    8    data word width, bits
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       reset; synchronous, active-high
//  in         in   WIDTH   input data word
//  in_valid   in   1       input word present
//  in_ready   out  1       demux can accept the input word this cycle
//  sel        in   2       target lane in mode 0 (0..3)
//  mode       in   1       0 = explicit sel, 1 = round-robin
//  out0..out3 out  WIDTH   lane data, registered
//  out_valid  out  4       bit k = lane k holds a word
//  out_ready  in   4       bit k = sink k accepts lane k this cycle
//  rr_ptr     out  2       current round-robin pointer (observability)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=4'b0, out0..3=0, rr_ptr=0. in_ready is
//    combinational, so it reads 1 right after reset.
//  - Target lane T = mode ? rr_ptr : sel. Combinational, same cycle.
//  - Each lane is a one-entry register slice (v_k, d_k).
//  - Lane k can load when ~v_k | out_ready[k].
//  - in_ready = ~v_T | out_ready[T]. in_ready never depends on in_valid.
//  - Accept = in_valid & in_ready. On accept: d_T <= in, v_T <= 1. Latency is 1 cycle,
//    input to out_valid.
//  - Drain: if v_k & out_ready[k] and lane k is not loaded this cycle, v_k <= 0.
//    Same-cycle drain and reload of lane k is allowed; v_k stays 1 and d_k takes the
//    new word. Full throughput of 1 word/clk into a continuously ready lane.
//  - Lanes other than T are unaffected by input; they drain independently.
//  - Hold rule: while v_k & ~out_ready[k], outk and v_k stay stable.
//  - Round-robin: in mode 1, rr_ptr <= rr_ptr+1 (mod 4, 3 wraps to 0) on each accept
//    only. A stalled lane blocks input; it does not skip ahead (strict order 0,1,2,3).
//  - In mode 0, rr_ptr holds its value. Switching mode takes effect in the same cycle;
//    the pointer is not reset.
//  - sel or mode changes while in_valid & ~in_ready are legal. T follows the new value.
//  - rst mid-transfer discards all lane contents. The input word presented in the rst
//    cycle is not accepted into any lane.
//  - No X propagation: out data registers reset to 0 and update only on load.
// STRUCTURE
//  - Package demux_pkg:
//    - localparam N_LANES=4, SEL_W=2
//    - MODE_SEL=1'b0, MODE_RR=1'b1
//  - Sub-module demux_lane (one-entry slice: clk, rst, load, d_in, ready_in, valid_out,
//    d_out, can_load), instantiated 4 times (LANE_u0..u3).
//  - Top level holds the target decode, the in_ready mux and rr_ptr. Roughly 150-200
//    lines in total.
// TESTING
//  1. Reset: assert rst 2 clks with in_valid=1 -> out_valid=0000, rr_ptr=0, no lane
//     loaded, and in_ready=1 after release.
//  2. Mode 0, sel=2, in=8'hA5, out_ready=4'hF -> next clk out_valid=0100, out2=A5.
//     The following clk out_valid=0000.
//  3. Mode 0 backpressure: out_ready[1]=0, send 8'h11 then 8'h22 to sel=1.
//     -> 8'h11 held in out1; in_ready=0 for the 2nd word.
//     -> raise out_ready[1]: 8'h11 drains and 8'h22 loads in the same cycle.
//  4. Mode 1, out_ready=4'hF, stream 8'h01..8'h06 -> lanes 0,1,2,3,0,1 in order.
//     rr_ptr ends at 2.
//  5. Mode 1 stall: out_ready[2]=0 with lane 2 full, rr_ptr=2 -> in_ready=0, rr_ptr
//     stays 2, lanes 0,1,3 still drain. Release -> accepts resume at lane 2.
//  6. Throughput: mode 0, sel=3, out_ready=4'hF, 16 back-to-back words -> 16 words on
//     out3, in order, with no bubbles.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 round-robin stream demultiplexer.
//   N_LANES  number of output lanes
//   SEL_W    width of the lane select and of the round-robin pointer
//   MODE_SEL explicit lane select taken from the sel input
//   MODE_RR  lane chosen by the internal round-robin pointer
package demux_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_lane.sv
// One-entry register slice used as a single output lane of the demux.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   load       write d_in into the slice this cycle
//   d_in       data word to load
//   ready_in   downstream sink accepts the held word this cycle
//   valid_out  slice holds a word
//   d_out      held word, registered
//   can_load   slice is empty or is being drained this cycle
module demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] d_out,
  output logic             can_load
);

  // A drain and a reload may coincide, which gives one word per clock
  // into a continuously ready sink.
  assign can_load = ~valid_out | ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      // NOTE: the data register is reset as well so a lane never presents X,
      // even though it is only meaningful while valid_out is set.
      d_out     <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      d_out     <= d_in;
    end else if (valid_out && ready_in) begin
      // Drained with no reload: data is kept, only valid drops.
      valid_out <= 1'b0;
    end
  end

endmodule : demux_lane

// File: rtl/demux1to4_rr.sv
// 1-to-4 registered stream demultiplexer with valid/ready on every port.
// Each accepted input word goes to one lane, chosen either by sel (mode 0)
// or by a round-robin pointer (mode 1) that advances only on accepts.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in         input data word
//   in_valid   input word present
//   in_ready   target lane can take a word this cycle (combinational)
//   sel        explicit target lane in mode 0
//   mode       0 = explicit sel, 1 = round-robin
//   out0..out3 lane data, registered
//   out_valid  bit k set while lane k holds a word
//   out_ready  bit k set when sink k takes lane k this cycle
//   rr_ptr     current round-robin pointer
module demux1to4_rr
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out0,
  output logic [WIDTH-1:0]   out1,
  output logic [WIDTH-1:0]   out2,
  output logic [WIDTH-1:0]   out3,
  output logic [N_LANES-1:0] out_valid,
  input  logic [N_LANES-1:0] out_ready,
  output logic [SEL_W-1:0]   rr_ptr
);

  logic [SEL_W-1:0]   target;
  logic [N_LANES-1:0] can_load;
  logic [N_LANES-1:0] load;
  logic               accept;

  // Target lane follows sel/mode in the same cycle, so a change while the
  // input is stalled simply retargets the pending word.
  assign target   = (mode == MODE_RR) ? rr_ptr : sel;
  // in_ready is independent of in_valid to avoid a handshake loop upstream.
  assign in_ready = can_load[target];
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: default assignment first so no latch is inferred for load.
    load = '0;
    if (accept) begin
      load[target] = 1'b1;
    end
  end

  // Pointer advances only on an accept, so a stalled lane holds the order
  // rather than being skipped. Natural wrap of the 2-bit counter gives 3 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      rr_ptr <= '0;
    end else if (accept && (mode == MODE_RR)) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  demux_lane #(.WIDTH(WIDTH)) LANE_u0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[0]),
    .d_in     (in),
    .ready_in (out_ready[0]),
    .valid_out(out_valid[0]),
    .d_out    (out0),
    .can_load (can_load[0])
  );

  demux_lane #(.WIDTH(WIDTH)) LANE_u1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[1]),
    .d_in     (in),
    .ready_in (out_ready[1]),
    .valid_out(out_valid[1]),
    .d_out    (out1),
    .can_load (can_load[1])
  );

  demux_lane #(.WIDTH(WIDTH)) LANE_u2 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[2]),
    .d_in     (in),
    .ready_in (out_ready[2]),
    .valid_out(out_valid[2]),
    .d_out    (out2),
    .can_load (can_load[2])
  );

  demux_lane #(.WIDTH(WIDTH)) LANE_u3 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[3]),
    .d_in     (in),
    .ready_in (out_ready[3]),
    .valid_out(out_valid[3]),
    .d_out    (out3),
    .can_load (can_load[3])
  );

endmodule : demux1to4_rr

// File: tb/tb_demux1to4_rr.sv
// Bench for demux1to4_rr: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the four lanes.
module tb_demux1to4_rr;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       mode;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;

  demux1to4_rr #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rr_ptr   (rr_ptr)
  );

  always #5 clk = ~clk;

  wire [7:0] outs [4];
  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;

  int checks = 0;
  int errors = 0;

  // Reference model: what each lane currently holds and where the pointer is.
  bit         m_full [4];
  logic [7:0] m_data [4];
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_target();
    return (mode == MODE_RR) ? m_ptr : int'(sel);
  endfunction

  function automatic bit model_ready();
    int t = model_target();
    return !m_full[t] || out_ready[t];
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v = '0;
    for (int k = 0; k < 4; k++) if (m_full[k]) v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 8'h00;
    end
    m_ptr = 0;
  endtask

  // Compare at the falling edge, advance the model with the inputs that the
  // coming rising edge will see, then return 1 time unit past that edge.
  task automatic step();
    int  t;
    bit  acc;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
    chk("out_valid", 32'(out_valid), 32'(model_valid()));
    chk("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    for (int k = 0; k < 4; k++) chk($sformatf("out%0d", k), 32'(outs[k]), 32'(m_data[k]));
    if (rst) begin
      model_clear();
    end else begin
      t   = model_target();
      acc = in_valid && model_ready();
      for (int k = 0; k < 4; k++) begin
        if (acc && k == t) begin
          m_full[k] = 1'b1;
          m_data[k] = din;
        end else if (m_full[k] && out_ready[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (acc && mode == MODE_RR) m_ptr = (m_ptr + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset held two clocks with a word presented: nothing is taken.
    rst = 1'b1; in_valid = 1'b1; din = 8'h5A; sel = 2'd0; mode = MODE_SEL;
    out_ready = 4'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    step();

    // 2. Explicit select to lane 2, sinks always ready.
    out_ready = 4'hF; sel = 2'd2; din = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_valid", 32'(out_valid), 32'h4);
    chk("t2_out2", 32'(out2), 32'hA5);
    step();
    chk("t2_drained", 32'(out_valid), 32'h0);

    // 3. Backpressure on lane 1, then simultaneous drain and reload.
    out_ready = 4'b1101; sel = 2'd1; din = 8'h11; in_valid = 1'b1;
    step();
    din = 8'h22;
    #1;
    chk("t3_blocked", 32'(in_ready), 32'h0);
    step();
    chk("t3_hold_out1", 32'(out1), 32'h11);
    chk("t3_hold_valid", 32'(out_valid[1]), 32'h1);
    out_ready = 4'hF;
    #1;
    chk("t3_unblocked", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("t3_reload_out1", 32'(out1), 32'h22);
    chk("t3_reload_valid", 32'(out_valid), 32'h2);
    step();

    // 4. Round-robin stream of six words: lanes 0,1,2,3,0,1.
    mode = MODE_RR; out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      din = 8'(i + 1); in_valid = 1'b1;
      step();
      chk("t4_lane_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      chk("t4_lane_data", 32'(outs[i % 4]), 32'(i + 1));
    end
    in_valid = 1'b0;
    chk("t4_rr_ptr", 32'(rr_ptr), 32'h2);
    step();

    // 5. Lane 2 stalled while it is the round-robin target.
    out_ready = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'h07 + i); in_valid = 1'b1;
      step();
    end
    din = 8'h0B;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_ready", 32'(in_ready), 32'h0);
      chk("t5_stall_ptr", 32'(rr_ptr), 32'h2);
      chk("t5_stall_valid", 32'(out_valid), 32'h4);
      chk("t5_stall_out2", 32'(out2), 32'h07);
    end
    out_ready = 4'hF;
    step();
    in_valid = 1'b0;
    chk("t5_resume_out2", 32'(out2), 32'h0B);
    chk("t5_resume_ptr", 32'(rr_ptr), 32'h3);
    step();

    // 6. Sixteen back-to-back words into lane 3 with no bubbles.
    mode = MODE_SEL; sel = 2'd3; out_ready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h80 + i); in_valid = 1'b1;
      step();
      chk("t6_out3", 32'(out3), 32'(8'h80 + i));
      chk("t6_valid3", 32'(out_valid[3]), 32'h1);
    end
    in_valid = 1'b0;
    step();

    // Random traffic, including occasional mid-transfer resets.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      din       = 8'($urandom);
      in_valid  = 1'($urandom);
      sel       = 2'($urandom);
      mode      = 1'($urandom_range(0, 3) != 0);
      out_ready = 4'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux1to4_rr
